// File: rtl/miss_queue_pkg.sv
// Shared definitions for the L1 miss queue: default geometry, trace command codes
// and the line-address type.
package miss_queue_pkg;

    localparam int         ADDR_W_DEF = 26;
    localparam int         DEPTH_DEF  = 8;
    localparam logic [3:0] CMD_RESET  = 4'd8;

    typedef logic [ADDR_W_DEF-1:0] line_addr_t;

endpackage

// File: rtl/miss_queue_match.sv
// Parallel compare of an incoming line address against every valid pending entry.
// The hit vector is one-hot because duplicates are never stored while coalescing is on.
module miss_queue_match
    import miss_queue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] entries,
    input  logic [DEPTH-1:0]             valid,
    input  logic [ADDR_W-1:0]            addr,
    output logic [DEPTH-1:0]             hit
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (entries[i] == addr);
        end
    end

endmodule

// File: rtl/miss_queue.sv
// Circular miss/write-through queue between the data cache and the next-level cache.
// Defining MISSQ_COALESCE_EN makes pushes that match a pending entry merge instead of storing.
module miss_queue
    import miss_queue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   n,
    input  logic                         in_valid,
    input  logic [ADDR_W-1:0]            in_addr,
    output logic                         l2_req,
    output logic [ADDR_W-1:0]            l2_addr,
    input  logic                         l2_ack,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic [31:0]                  drops,
    output logic [31:0]                  merges
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [31:0]                    drops_q, drops_d;
    logic [DEPTH-1:0][ADDR_W-1:0]   mem_q, mem_d;

    logic flush;
    logic full_w;
    logic empty_w;
    logic pop;
    logic hit;
    logic push;
    logic drop;

    assign flush   = (n == CMD_RESET);
    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    assign pop     = l2_ack && !empty_w && !flush;

`ifdef MISSQ_COALESCE_EN
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] hit_live;
    logic [31:0]      merges_q, merges_d;

    miss_queue_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_match (
        .entries (mem_q),
        .valid   (valid_q),
        .addr    (in_addr),
        .hit     (hit_vec)
    );

    // The head leaving this cycle can no longer absorb a new request.
    always_comb begin
        hit_live = hit_vec;
        if (pop) begin
            hit_live[rd_ptr_q] = 1'b0;
        end
    end

    assign hit = |hit_live;

    always_comb begin
        valid_d  = valid_q;
        merges_d = merges_q;
        if (flush) begin
            valid_d  = '0;
            merges_d = '0;
        end else begin
            if (push) begin
                valid_d[wr_ptr_q] = 1'b1;
            end
            if (pop) begin
                valid_d[rd_ptr_q] = 1'b0;
            end
            if (in_valid && hit) begin
                merges_d = merges_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            merges_q <= '0;
        end else begin
            valid_q  <= valid_d;
            merges_q <= merges_d;
        end
    end

    assign merges = merges_q;
`else
    assign hit    = 1'b0;
    assign merges = '0;
`endif

    assign push = in_valid && !flush && !hit && !full_w;
    assign drop = in_valid && !flush && !hit &&  full_w;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drops_d  = drops_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            drops_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_addr;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (drop) begin
                drops_d = drops_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drops_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drops_q  <= drops_d;
        end
    end

    // Entry storage carries no reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign l2_req  = !empty_w;
    assign l2_addr = mem_q[rd_ptr_q];
    assign full    = full_w;
    assign empty   = empty_w;
    assign count   = count_q;
    assign drops   = drops_q;

endmodule
